noc_rsc_ni: RTL and testbench
=============================

NOC_RSC_NI -- requirements
Module: noc_rsc_ni

Interface
REQ-001 Parameter ROW_N, default 3, mesh row count.
REQ-002 Parameter COL_M, default 3, mesh column count.
REQ-003 Parameter PCKT_DATA_W, default 8, payload width.
REQ-004 Parameter FIFO_DEPTH_W, default 2; each FIFO holds 2**FIFO_DEPTH_W packets.
REQ-005 Parameter X_CORD, default 0, own row index; Y_CORD, default 0, own column index.
REQ-006 PACKET_W SHALL equal PCKT_DATA_W + clog2(ROW_N) + clog2(COL_M), packed as {dst_x (MSBs), dst_y, data (LSBs)}.
REQ-007 clk_i  input  1  clock; the only clock.
REQ-008 rst_ni  input  1  reset, synchronous, active-low.
REQ-009 tx_valid_i  input  1  resource offers a packet.
REQ-010 tx_ready_o  output  1  TX FIFO can accept.
REQ-011 tx_pckt_i  input  PACKET_W  packet from resource.
REQ-012 noc_pckt_o  output  PACKET_W  packet to switch local port.
REQ-013 noc_wren_o  output  1  write strobe to switch.
REQ-014 noc_full_i  input  1  switch local input FIFO full.
REQ-015 noc_ovrflw_i  input  1  switch local input FIFO overflowed.
REQ-016 noc_pckt_i  input  PACKET_W  packet from switch local output.
REQ-017 noc_wren_i  input  1  write strobe from switch.
REQ-018 noc_full_o  output  1  RX FIFO full.
REQ-019 noc_ovrflw_o  output  1  RX drop pulse.
REQ-020 rx_valid_o  output  1  RX data available; rx_ready_i  input  1  resource pops.
REQ-021 rx_data_o  output  PCKT_DATA_W  head payload, address stripped.
REQ-022 ovrflw_cnt_o  output  8  saturating TX-overflow count; drop_cnt_o  output  8  saturating RX drop count.

Function
REQ-023 TX push when tx_valid_i && tx_ready_o; tx_ready_o = !tx_fifo_full; no same-cycle bypass; earliest noc_wren_o is the cycle after push.
REQ-024 TX FSM states: IDLE, SEND, STALL.
REQ-025 IDLE: noc_wren_o=0; to SEND when TX FIFO non-empty.
REQ-026 SEND: noc_wren_o = !noc_full_i; noc_pckt_o = TX head; head popped in every cycle noc_wren_o=1; to IDLE when last entry popped and no push that cycle.
REQ-027 noc_ovrflw_i=1 in any state: go to STALL, load 2-bit stall counter with 3, ovrflw_cnt_o +1 (saturate at 255); no retransmit.
REQ-028 STALL: noc_wren_o=0; counter decrements each cycle; on reaching 0 and noc_full_i=0 go to SEND if non-empty else IDLE; noc_ovrflw_i during STALL reloads counter.
REQ-029 noc_pckt_o SHALL be 0 whenever noc_wren_o=0.
REQ-030 RX push when noc_wren_i=1, TX-unrelated; noc_full_o = rx_fifo_full, derived from registered count only.
REQ-031 noc_wren_i while noc_full_o=1: packet dropped even if a pop occurs that cycle; noc_ovrflw_o=1 next cycle for exactly one cycle per drop; drop_cnt_o +1 saturating.
REQ-032 Packet whose dst_x!=X_CORD or dst_y!=Y_CORD: not stored, drop_cnt_o +1, noc_ovrflw_o not asserted.
REQ-033 rx_valid_o = !rx_fifo_empty; rx_data_o = head payload; pop when rx_valid_o && rx_ready_i; push to pop latency 1 cycle.
REQ-034 Simultaneous push and pop on non-full non-empty FIFO: count unchanged, order preserved; pointers wrap modulo depth.

Reset
REQ-035 rst_ni=0 at a clock edge: FIFOs emptied, FSM to IDLE, stall counter 0, both counters 0, noc_ovrflw_o=0, noc_wren_o=0, noc_pckt_o=0, tx_ready_o=1, rx_valid_o=0, noc_full_o=0.
REQ-036 Reset mid-transfer discards all buffered packets; no partial strobe after release.

Verification
REQ-037 Push 4 packets (defaults), noc_full_i=0 -> noc_wren_o high 4 consecutive cycles from cycle after first push, same order, tx_ready_o=0 when 4 buffered and no pop.
REQ-038 noc_full_i=1 for 5 cycles in SEND -> noc_wren_o=0 those cycles, head retained, resumes next cycle after release.
REQ-039 noc_ovrflw_i pulse -> ovrflw_cnt_o=1, noc_wren_o=0 for 3 cycles, then SEND.
REQ-040 5 RX writes to own address, rx_ready_i=0 -> noc_full_o=1 after 4th, 5th dropped, noc_ovrflw_o one-cycle pulse, drop_cnt_o=1.
REQ-041 RX write with dst_x=1 at X_CORD=0 -> rx_valid_o stays 0, drop_cnt_o=1, noc_ovrflw_o=0.
REQ-042 rst_ni=0 with both FIFOs holding 2 entries -> all outputs at REQ-035 values next cycle.

Source files
------------

// File: rtl/noc_rsc_ni_if.sv
// Bundle of resource-side and switch-side signals of the NoC network interface.
// The slave modport is the NI's view; the master modport is the view of its surroundings.
interface noc_rsc_ni_if #(
  parameter int unsigned ROW_N       = 3,
  parameter int unsigned COL_M       = 3,
  parameter int unsigned PCKT_DATA_W = 8
);
  localparam int unsigned PACKET_W = PCKT_DATA_W + $clog2(ROW_N) + $clog2(COL_M);

  logic                   tx_valid_i;
  logic                   tx_ready_o;
  logic [PACKET_W-1:0]    tx_pckt_i;
  logic [PACKET_W-1:0]    noc_pckt_o;
  logic                   noc_wren_o;
  logic                   noc_full_i;
  logic                   noc_ovrflw_i;
  logic [PACKET_W-1:0]    noc_pckt_i;
  logic                   noc_wren_i;
  logic                   noc_full_o;
  logic                   noc_ovrflw_o;
  logic                   rx_valid_o;
  logic                   rx_ready_i;
  logic [PCKT_DATA_W-1:0] rx_data_o;
  logic [7:0]             ovrflw_cnt_o;
  logic [7:0]             drop_cnt_o;

  modport slave (
    input  tx_valid_i, tx_pckt_i, noc_full_i, noc_ovrflw_i, noc_pckt_i, noc_wren_i, rx_ready_i,
    output tx_ready_o, noc_pckt_o, noc_wren_o, noc_full_o, noc_ovrflw_o, rx_valid_o, rx_data_o,
           ovrflw_cnt_o, drop_cnt_o
  );

  modport master (
    output tx_valid_i, tx_pckt_i, noc_full_i, noc_ovrflw_i, noc_pckt_i, noc_wren_i, rx_ready_i,
    input  tx_ready_o, noc_pckt_o, noc_wren_o, noc_full_o, noc_ovrflw_o, rx_valid_o, rx_data_o,
           ovrflw_cnt_o, drop_cnt_o
  );
endinterface

// File: rtl/noc_rsc_ni.sv
// Resource network interface: TX FIFO feeding a switch local port under an IDLE/SEND/STALL FSM,
// and an address-filtering RX FIFO that strips the destination before handing payloads out.
module noc_rsc_ni #(
  parameter int unsigned ROW_N        = 3,
  parameter int unsigned COL_M        = 3,
  parameter int unsigned PCKT_DATA_W  = 8,
  parameter int unsigned FIFO_DEPTH_W = 2,
  parameter int unsigned X_CORD       = 0,
  parameter int unsigned Y_CORD       = 0
) (
  input logic         clk_i,
  input logic         rst_ni,
  noc_rsc_ni_if.slave bus
);
  localparam int unsigned XW       = $clog2(ROW_N);
  localparam int unsigned YW       = $clog2(COL_M);
  localparam int unsigned PACKET_W = PCKT_DATA_W + XW + YW;
  localparam int unsigned DEPTH    = 1 << FIFO_DEPTH_W;

  typedef logic [FIFO_DEPTH_W-1:0] ptr_t;
  typedef logic [FIFO_DEPTH_W:0]   cnt_t;
  typedef enum logic [1:0] {StIdle, StSend, StStall} tx_state_e;

  // ---------------- TX path ----------------
  logic [PACKET_W-1:0] tx_mem_q [DEPTH];
  ptr_t                tx_wr_q, tx_rd_q;
  cnt_t                tx_cnt_q, tx_cnt_d;
  logic                tx_full, tx_empty, tx_push, tx_pop;
  tx_state_e           state_q, state_d;
  logic [1:0]          stall_q, stall_d;
  logic [7:0]          ovrflw_cnt_q;

  assign tx_full        = (tx_cnt_q == cnt_t'(DEPTH));
  assign tx_empty       = (tx_cnt_q == '0);
  assign tx_push        = bus.tx_valid_i && !tx_full;
  assign tx_pop         = (state_q == StSend) && !bus.noc_full_i && !tx_empty;
  assign tx_cnt_d       = tx_cnt_q + cnt_t'(tx_push) - cnt_t'(tx_pop);
  assign bus.tx_ready_o = !tx_full;
  assign bus.noc_wren_o = tx_pop;
  assign bus.noc_pckt_o = tx_pop ? tx_mem_q[tx_rd_q] : '0;
  assign bus.ovrflw_cnt_o = ovrflw_cnt_q;

  // Transitions look at the post-update occupancy so a push in IDLE strobes the very next cycle.
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    unique case (state_q)
      StIdle: if (tx_cnt_d != '0) state_d = StSend;
      StSend: if (tx_cnt_d == '0) state_d = StIdle;
      StStall: begin
        stall_d = (stall_q == 2'd0) ? 2'd0 : stall_q - 2'd1;
        if (stall_q <= 2'd1 && !bus.noc_full_i) begin
          state_d = (tx_cnt_d != '0) ? StSend : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.noc_ovrflw_i) begin
      state_d = StStall;
      stall_d = 2'd3;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      stall_q      <= 2'd0;
      tx_wr_q      <= '0;
      tx_rd_q      <= '0;
      tx_cnt_q     <= '0;
      ovrflw_cnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      tx_cnt_q <= tx_cnt_d;
      if (tx_push) tx_wr_q <= tx_wr_q + ptr_t'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + ptr_t'(1);
      if (bus.noc_ovrflw_i && ovrflw_cnt_q != 8'hFF) ovrflw_cnt_q <= ovrflw_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= bus.tx_pckt_i;
  end

  // ---------------- RX path ----------------
  logic [PCKT_DATA_W-1:0] rx_mem_q [DEPTH];
  ptr_t                   rx_wr_q, rx_rd_q;
  cnt_t                   rx_cnt_q;
  logic                   rx_full, rx_empty, rx_addr_ok, rx_push, rx_pop, rx_drop_full, rx_drop;
  logic                   rx_ovrflw_q;
  logic [7:0]             drop_cnt_q;
  logic [XW-1:0]          rx_dst_x;
  logic [YW-1:0]          rx_dst_y;

  assign rx_dst_x     = bus.noc_pckt_i[PACKET_W-1 -: XW];
  assign rx_dst_y     = bus.noc_pckt_i[PCKT_DATA_W +: YW];
  assign rx_addr_ok   = (rx_dst_x == XW'(X_CORD)) && (rx_dst_y == YW'(Y_CORD));
  assign rx_full      = (rx_cnt_q == cnt_t'(DEPTH));
  assign rx_empty     = (rx_cnt_q == '0);
  // Fullness comes from the registered count, so a same-cycle pop does not rescue a write.
  assign rx_push      = bus.noc_wren_i && rx_addr_ok && !rx_full;
  assign rx_drop_full = bus.noc_wren_i && rx_addr_ok && rx_full;
  assign rx_drop      = bus.noc_wren_i && !rx_push;
  assign rx_pop       = !rx_empty && bus.rx_ready_i;

  assign bus.noc_full_o   = rx_full;
  assign bus.noc_ovrflw_o = rx_ovrflw_q;
  assign bus.rx_valid_o   = !rx_empty;
  assign bus.rx_data_o    = rx_mem_q[rx_rd_q];
  assign bus.drop_cnt_o   = drop_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      rx_cnt_q    <= '0;
      rx_ovrflw_q <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      rx_cnt_q    <= rx_cnt_q + cnt_t'(rx_push) - cnt_t'(rx_pop);
      rx_ovrflw_q <= rx_drop_full;
      if (rx_push) rx_wr_q <= rx_wr_q + ptr_t'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + ptr_t'(1);
      if (rx_drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= bus.noc_pckt_i[PCKT_DATA_W-1:0];
  end
endmodule

// File: tb/tb_noc_rsc_ni.sv
// Scoreboard bench for noc_rsc_ni: packets are queued as they are offered and matched
// against the switch strobe and the RX pop stream, alongside directed timing checks.
module tb_noc_rsc_ni;
  localparam int unsigned PW    = 12;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  noc_rsc_ni_if bus ();

  noc_rsc_ni dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  logic [PW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  int   ovr_cnt_exp = 0;
  int   drop_exp    = 0;
  logic pulse_exp   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called once per cycle after inputs settle; checks against the model, then applies this
  // cycle's pushes and pops to it.
  task automatic monitor();
    int            tx_n = tx_q.size();
    int            rx_n = rx_q.size();
    logic [PW-1:0] p;
    logic [DW-1:0] d;
    check("tx_ready",   32'(bus.tx_ready_o),   32'(tx_n != DEPTH));
    check("noc_full",   32'(bus.noc_full_o),   32'(rx_n == DEPTH));
    check("rx_valid",   32'(bus.rx_valid_o),   32'(rx_n != 0));
    check("ovrflw_cnt", 32'(bus.ovrflw_cnt_o), 32'(ovr_cnt_exp));
    check("drop_cnt",   32'(bus.drop_cnt_o),   32'(drop_exp));
    check("noc_ovrflw", 32'(bus.noc_ovrflw_o), 32'(pulse_exp));
    if (bus.noc_wren_o) begin
      if (tx_n == 0) check("tx_underflow", 32'(tx_n), 32'd1);
      else begin
        p = tx_q.pop_front();
        check("noc_pckt", 32'(bus.noc_pckt_o), 32'(p));
      end
    end else begin
      check("noc_pckt_idle", 32'(bus.noc_pckt_o), 32'd0);
    end
    if (bus.tx_valid_i && tx_n != DEPTH) tx_q.push_back(bus.tx_pckt_i);
    if (rx_n != 0 && bus.rx_ready_i) begin
      d = rx_q.pop_front();
      check("rx_data", 32'(bus.rx_data_o), 32'(d));
    end
    pulse_exp = 1'b0;
    if (bus.noc_wren_i) begin
      if (bus.noc_pckt_i[PW-1:DW] != 4'd0) begin
        if (drop_exp != 255) drop_exp++;
      end else if (rx_n == DEPTH) begin
        if (drop_exp != 255) drop_exp++;
        pulse_exp = 1'b1;
      end else begin
        rx_q.push_back(bus.noc_pckt_i[DW-1:0]);
      end
    end
    if (bus.noc_ovrflw_i && ovr_cnt_exp != 255) ovr_cnt_exp++;
  endtask

  task automatic sample_point();
    #4;
  endtask

  task automatic finish_cycle();
    if (mon_en) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample_point();
    finish_cycle();
  endtask

  task automatic idle();
    bus.tx_valid_i   = 1'b0;
    bus.noc_wren_i   = 1'b0;
    bus.noc_ovrflw_i = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    idle();
    rst_n = 1'b0;
    cycle();
    cycle();
    tx_q.delete();
    rx_q.delete();
    ovr_cnt_exp = 0;
    drop_exp    = 0;
    pulse_exp   = 1'b0;
    rst_n = 1'b1;
    sample_point();
    check("rst_wren",     32'(bus.noc_wren_o),   32'd0);
    check("rst_pckt",     32'(bus.noc_pckt_o),   32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready_o),   32'd1);
    check("rst_rx_valid", 32'(bus.rx_valid_o),   32'd0);
    check("rst_noc_full", 32'(bus.noc_full_o),   32'd0);
    check("rst_ovrflw_o", 32'(bus.noc_ovrflw_o), 32'd0);
    check("rst_ovr_cnt",  32'(bus.ovrflw_cnt_o), 32'd0);
    check("rst_drop_cnt", 32'(bus.drop_cnt_o),   32'd0);
    mon_en = 1'b1;
    finish_cycle();
  endtask

  task automatic rx_own(input logic [DW-1:0] data);
    bus.noc_wren_i = 1'b1;
    bus.noc_pckt_i = {4'd0, data};
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.tx_pckt_i  = '0;
    bus.noc_pckt_i = '0;
    bus.noc_full_i = 1'b0;
    bus.rx_ready_i = 1'b0;
    idle();
    @(posedge clk);
    #1;
    do_reset();

    // Four back-to-back pushes drain on four consecutive strobes starting one cycle later.
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k < 4) begin
        bus.tx_valid_i = 1'b1;
        bus.tx_pckt_i  = PW'($urandom);
      end
      sample_point();
      check("burst_wren", 32'(bus.noc_wren_o), 32'(k >= 1 && k <= 4));
      finish_cycle();
    end

    // Switch full: FIFO fills, strobe held off five SEND cycles, then drains in order.
    bus.noc_full_i = 1'b1;
    for (int k = 0; k < 11; k++) begin
      idle();
      if (k < 4) begin
        bus.tx_valid_i = 1'b1;
        bus.tx_pckt_i  = PW'($urandom);
      end
      if (k == 6) bus.noc_full_i = 1'b0;
      sample_point();
      check("full_wren", 32'(bus.noc_wren_o), 32'(k >= 6 && k <= 9));
      if (k == 4) check("full_tx_ready", 32'(bus.tx_ready_o), 32'd0);
      finish_cycle();
    end

    // Overflow pulse together with a push: three stall cycles, then the packet goes out.
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k == 0) begin
        bus.noc_ovrflw_i = 1'b1;
        bus.tx_valid_i   = 1'b1;
        bus.tx_pckt_i    = PW'($urandom);
      end
      sample_point();
      check("stall_wren", 32'(bus.noc_wren_o), 32'(k == 4));
      if (k == 1) check("stall_ovr_cnt", 32'(bus.ovrflw_cnt_o), 32'd1);
      finish_cycle();
    end

    // Five RX writes without popping: fifth is dropped with a single-cycle pulse.
    for (int k = 0; k < 8; k++) begin
      idle();
      if (k < 5) rx_own(DW'($urandom));
      sample_point();
      check("rxfill_full", 32'(bus.noc_full_o), 32'(k >= 4));
      check("rxfill_pulse", 32'(bus.noc_ovrflw_o), 32'(k == 5));
      if (k == 5) check("rxfill_drop", 32'(bus.drop_cnt_o), 32'd1);
      finish_cycle();
    end

    // Write into a full FIFO while popping: still dropped.
    idle();
    bus.rx_ready_i = 1'b1;
    rx_own(DW'($urandom));
    cycle();
    idle();
    sample_point();
    check("popfull_pulse", 32'(bus.noc_ovrflw_o), 32'd1);
    check("popfull_drop", 32'(bus.drop_cnt_o), 32'd2);
    finish_cycle();

    // Streaming push/pop with pointer wrap, random ready.
    for (int k = 0; k < 24; k++) begin
      idle();
      rx_own(DW'($urandom));
      bus.rx_ready_i = 1'($urandom);
      cycle();
    end
    idle();
    bus.rx_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) cycle();

    // Foreign destination: counted as a drop, never stored, no pulse.
    do_reset();
    bus.rx_ready_i = 1'b0;
    bus.noc_wren_i = 1'b1;
    bus.noc_pckt_i = {2'd1, 2'd0, 8'hA5};
    cycle();
    idle();
    sample_point();
    check("foreign_valid", 32'(bus.rx_valid_o), 32'd0);
    check("foreign_drop", 32'(bus.drop_cnt_o), 32'd1);
    check("foreign_pulse", 32'(bus.noc_ovrflw_o), 32'd0);
    finish_cycle();

    // Continuous overflow saturates the counter at 255.
    for (int k = 0; k < 260; k++) begin
      idle();
      bus.noc_ovrflw_i = 1'b1;
      cycle();
    end
    idle();
    sample_point();
    check("ovr_sat", 32'(bus.ovrflw_cnt_o), 32'd255);
    finish_cycle();
    for (int k = 0; k < 4; k++) cycle();

    // Mixed random traffic on both directions.
    for (int k = 0; k < 200; k++) begin
      idle();
      bus.noc_full_i = ($urandom_range(0, 3) == 0);
      bus.rx_ready_i = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        bus.tx_valid_i = 1'b1;
        bus.tx_pckt_i  = PW'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        bus.noc_wren_i = 1'b1;
        bus.noc_pckt_i = ($urandom_range(0, 5) == 0) ? PW'($urandom) : {4'd0, DW'($urandom)};
      end
      bus.noc_ovrflw_i = ($urandom_range(0, 19) == 0);
      cycle();
    end

    // Reset with two entries buffered on each side.
    idle();
    bus.noc_full_i = 1'b1;
    bus.rx_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) cycle();
    bus.rx_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idle();
      bus.tx_valid_i = 1'b1;
      bus.tx_pckt_i  = PW'($urandom);
      rx_own(DW'($urandom));
      cycle();
    end
    idle();
    sample_point();
    check("pre_rst_rx_valid", 32'(bus.rx_valid_o), 32'd1);
    finish_cycle();
    bus.noc_full_i = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      sample_point();
      check("post_rst_wren", 32'(bus.noc_wren_o), 32'd0);
      finish_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
